mem_1r1w_masked_32x64_sched: RTL
================================

Name: mem_1r1w_masked_32x64_sched

Overview:
- Single-clock port scheduler in front of the 1R1W masked 32x64 SRAM wrapper (R0_*/W0_* ports).
- Zero-fills the array after reset.
- Shares the single write port between two requesters using round-robin arbitration.
- Serves one read requester with fixed 1-cycle latency, with write-first forwarding when a read and a write hit the same address in the same cycle. The SRAM macro's own collision result is undefined.

Parameters:
- DEPTH, 32, number of words; ADDR_W = log2(DEPTH).
- WIDTH, 64, word width in bits.
- MASK_GRAN, 8, bits per mask lane; MASK_W = WIDTH/MASK_GRAN.
- INIT_VALUE, 0, word value written to every address during init.

Ports:
- clock  in  1  single clock for all logic and both SRAM ports.
- reset_n  in  1  asynchronous, active-low reset.
- wr0_valid / wr1_valid  in  1  write request valid.
- wr0_ready / wr1_ready  out  1  write granted this cycle.
- wr0_addr / wr1_addr  in  ADDR_W  write address.
- wr0_data / wr1_data  in  WIDTH  write data.
- wr0_mask / wr1_mask  in  MASK_W  lane write enables.
- rd_valid  in  1  read request valid.
- rd_ready  out  1  read accepted.
- rd_addr  in  ADDR_W  read address.
- rd_resp_valid  out  1  read data valid. No backpressure on the response.
- rd_resp_data  out  WIDTH  read data.
- init_done  out  1  high once the zero-fill is complete.
- R0_addr  out  ADDR_W  to SRAM.
- R0_en  out  1  to SRAM.
- R0_data  in  WIDTH  from SRAM; valid the cycle after R0_en.
- W0_addr  out  ADDR_W  to SRAM.
- W0_en  out  1  to SRAM.
- W0_data  out  WIDTH  to SRAM.
- W0_mask  out  MASK_W  to SRAM.

Behaviour:
- Reset (async assert, synchronous release):
  - State enters INIT; init counter = 0; round-robin pointer = wr0.
  - Outputs: init_done=0, rd_resp_valid=0, rd_resp_data=0.
  - Combinational outputs are forced low by the INIT state: all readies=0, R0_en=0.
- State machine: INIT -> RUN. There is no other transition; only reset returns to INIT.
- INIT:
  - Each cycle: W0_en=1, W0_addr=counter, W0_data=INIT_VALUE, W0_mask=all ones; counter increments.
  - After address DEPTH-1 is written, go to RUN. init_done rises in the first RUN cycle, i.e. DEPTH cycles after reset release.
  - wr*_ready=0, rd_ready=0, R0_en=0 throughout.
- RUN, writes:
  - Winner is chosen combinationally:
    - only one requester valid: that one wins;
    - both valid: the requester named by the pointer wins.
  - Winner's ready=1 and the loser's ready=0. The ready signals do not depend on the other requester's ready.
  - W0_en, W0_addr, W0_data and W0_mask are driven combinationally from the winner, so the write lands in the same cycle.
  - Pointer update on each grant: pointer := the non-winner. With no grant the pointer holds.
- RUN, reads:
  - rd_ready=1. R0_en = rd_valid; R0_addr = rd_addr.
  - Response one cycle later: rd_resp_valid=1, rd_resp_data registered from the merged result below.
  - Back-to-back reads each cycle are supported: throughput is 1 per cycle.
- Collision (read and granted write in the same cycle at the same address):
  - Capture write data, mask and a collision flag.
  - Next cycle, for each lane i: rd_resp_data lane i = mask[i] ? captured write lane : R0_data lane.
  - Unmasked lanes return the old contents; the result is write-first.
- A write to the read address in the response cycle itself does not affect that response.
- Addresses are always in range (ADDR_W bits); there is no address decode.
- Reset mid-INIT or mid-RUN:
  - Any in-flight response is dropped.
  - Zero-fill restarts from address 0.

Test Plan:
- Reset release -> W0_en=1 for exactly 32 cycles, addr 0..31, mask 0xFF, data 0; init_done rises in cycle 33; all readies 0 meanwhile.
- After init, wr0 and wr1 both held valid for 4 cycles -> grants alternate wr0,wr1,wr0,wr1. Then wr1 alone for 2 cycles -> granted both cycles, after which wr0 wins the next contention.
- Write addr 5 data 0x1122334455667788 mask 0xFF; read addr 5 two cycles later -> rd_resp_valid one cycle after the read with the same data. A read of untouched addr 9 -> 0.
- Addr 3 holds 0xFFFFFFFFFFFFFFFF; same cycle, write addr 3 data 0 mask 0x0F and read addr 3 -> response 0xFFFFFFFF00000000.
- Assert reset_n low at init counter=10, release -> init restarts at addr 0 and takes a full 32 cycles.
- Assert reset_n low in the cycle a read is accepted in RUN -> rd_resp_valid stays 0 and init restarts.

Source files
------------

// File: rtl/mem_1r1w_masked_32x64_sched.sv
// Port scheduler for a 1R1W masked SRAM: zero-fill after reset, round-robin sharing of the
// write port between two requesters, and a 1-cycle read path with write-first forwarding.
module mem_1r1w_masked_32x64_sched #(
   parameter int unsigned DEPTH = 32,
   parameter int unsigned WIDTH = 64,
   parameter int unsigned MASK_GRAN = 8,
   parameter logic [WIDTH-1:0] INIT_VALUE = '0,
   localparam int unsigned ADDR_W = $clog2(DEPTH),
   localparam int unsigned MASK_W = WIDTH / MASK_GRAN
) (
   input  logic              clock_i,
   input  logic              reset_n_i,
   input  logic              wr0_valid_i,
   output logic              wr0_ready_o,
   input  logic [ADDR_W-1:0] wr0_addr_i,
   input  logic [WIDTH-1:0]  wr0_data_i,
   input  logic [MASK_W-1:0] wr0_mask_i,
   input  logic              wr1_valid_i,
   output logic              wr1_ready_o,
   input  logic [ADDR_W-1:0] wr1_addr_i,
   input  logic [WIDTH-1:0]  wr1_data_i,
   input  logic [MASK_W-1:0] wr1_mask_i,
   input  logic              rd_valid_i,
   output logic              rd_ready_o,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic              rd_resp_valid_o,
   output logic [WIDTH-1:0]  rd_resp_data_o,
   output logic              init_done_o,
   output logic [ADDR_W-1:0] R0_addr_o,
   output logic              R0_en_o,
   input  logic [WIDTH-1:0]  R0_data_i,
   output logic [ADDR_W-1:0] W0_addr_o,
   output logic              W0_en_o,
   output logic [WIDTH-1:0]  W0_data_o,
   output logic [MASK_W-1:0] W0_mask_o
);

   typedef enum logic [0:0] {StInit, StRun} state_e;

   state_e              state_q;
   logic [ADDR_W-1:0]   init_cnt_q;
   logic                rr_q;  // 0: wr0 wins contention, 1: wr1 wins
   logic                init_done_q;
   logic                resp_valid_q;
   logic                coll_q;
   logic [WIDTH-1:0]    coll_data_q;
   logic [MASK_W-1:0]   coll_mask_q;

   logic run;
   logic gnt0, gnt1;
   logic coll;

   assign run  = (state_q == StRun);
   assign gnt0 = run & wr0_valid_i & (~wr1_valid_i | ~rr_q);
   assign gnt1 = run & wr1_valid_i & (~wr0_valid_i | rr_q);

   assign wr0_ready_o = gnt0;
   assign wr1_ready_o = gnt1;
   assign rd_ready_o  = run;
   assign R0_en_o     = run & rd_valid_i;
   assign R0_addr_o   = rd_addr_i;
   assign init_done_o = init_done_q;
   assign rd_resp_valid_o = resp_valid_q;

   always_comb begin
      W0_en_o   = 1'b0;
      W0_addr_o = wr0_addr_i;
      W0_data_o = wr0_data_i;
      W0_mask_o = wr0_mask_i;
      if (!run) begin
         W0_en_o   = 1'b1;
         W0_addr_o = init_cnt_q;
         W0_data_o = INIT_VALUE;
         W0_mask_o = '1;
      end else if (gnt1) begin
         W0_en_o   = 1'b1;
         W0_addr_o = wr1_addr_i;
         W0_data_o = wr1_data_i;
         W0_mask_o = wr1_mask_i;
      end else begin
         W0_en_o   = gnt0;
      end
   end

   assign coll = R0_en_o & W0_en_o & (W0_addr_o == rd_addr_i);

   // Response lanes merge the captured write over the SRAM data; zero when no response.
   always_comb begin
      rd_resp_data_o = '0;
      if (resp_valid_q) begin
         for (int i = 0; i < int'(MASK_W); i++) begin
            rd_resp_data_o[i*MASK_GRAN +: MASK_GRAN] = (coll_q && coll_mask_q[i]) ?
                  coll_data_q[i*MASK_GRAN +: MASK_GRAN] : R0_data_i[i*MASK_GRAN +: MASK_GRAN];
         end
      end
   end

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q      <= StInit;
         init_cnt_q   <= '0;
         rr_q         <= 1'b0;
         init_done_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         coll_q       <= 1'b0;
         coll_data_q  <= '0;
         coll_mask_q  <= '0;
      end else begin
         unique case (state_q)
            StInit: begin
               init_cnt_q <= init_cnt_q + 1'b1;
               if (init_cnt_q == ADDR_W'(DEPTH - 1)) begin
                  state_q     <= StRun;
                  init_done_q <= 1'b1;
               end
            end
            StRun: begin
               if (gnt0) begin
                  rr_q <= 1'b1;
               end else if (gnt1) begin
                  rr_q <= 1'b0;
               end
            end
            default: state_q <= StInit;
         endcase
         resp_valid_q <= R0_en_o;
         coll_q       <= coll;
         if (coll) begin
            coll_data_q <= W0_data_o;
            coll_mask_q <= W0_mask_o;
         end
      end
   end

endmodule
